branch_history_cache: RTL and testbench



---
 rtl/bhc_pkg.sv | 21 ++
 rtl/bhc_match.sv | 36 +++
 rtl/branch_history_cache.sv | 99 +++++++++
 tb/tb_branch_history_cache.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bhc_pkg.sv
// Shared types and helpers for the branch-history cache.
// The entry struct is sized by the package defaults; instantiate with matching parameters.
package bhc_pkg;

  localparam int BHC_PC_W    = 10;
  localparam int BHC_HIST_W  = 3;
  localparam int BHC_ENTRIES = 8;

  typedef struct packed {
    logic                  valid;
    logic [BHC_PC_W-1:0]   tag;
    logic [BHC_HIST_W-1:0] hist;
  } bhc_entry_t;

  // Oldest outcome drops off the top, newest enters at bit 0.
  function automatic logic [BHC_HIST_W-1:0] shift_hist(input logic [BHC_HIST_W-1:0] hist,
                                                       input logic                  taken);
    return {hist[BHC_HIST_W-2:0], taken};
  endfunction

endpackage

// File: rtl/bhc_match.sv
// Tag match across all entries: hit, lowest matching index, lowest free index, full flag.
module bhc_match
  import bhc_pkg::*;
#(
  parameter int PC_W    = BHC_PC_W,
  parameter int ENTRIES = BHC_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  bhc_entry_t       entries [ENTRIES],
  input  logic [PC_W-1:0]  addr,
  output logic             hit,
  output logic [IDX_W-1:0] match_idx,
  output logic [IDX_W-1:0] free_idx,
  output logic             full
);

  // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    hit       = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    full      = 1'b1;
    // Scanning from the top down lets the lowest index overwrite any higher one.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].tag == addr)) begin
        hit       = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!entries[i].valid) begin
        full     = 1'b0;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/branch_history_cache.sv
// Fully-associative PC -> taken/not-taken history cache with round-robin eviction.
// Define BHC_BYPASS_EN to forward a same-cycle update to the read port.
module branch_history_cache
  import bhc_pkg::*;
#(
  parameter int PC_W    = BHC_PC_W,
  parameter int HIST_W  = BHC_HIST_W,
  parameter int ENTRIES = BHC_ENTRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   update_pc,
  output logic [HIST_W-1:0] read_history,
  output logic              read_hit,
  output logic [HIST_W-1:0] update_history,
  output logic              evict
);

  localparam int IDX_W = $clog2(ENTRIES);

  bhc_entry_t       entries [ENTRIES];
  logic [IDX_W-1:0] rr;

  logic             rd_hit, rd_full, upd_hit, upd_full;
  logic [IDX_W-1:0] rd_idx, rd_free, upd_idx, upd_free;

  bhc_match #(.PC_W(PC_W), .ENTRIES(ENTRIES)) u_rd_match (
    .entries   (entries),
    .addr      (pc),
    .hit       (rd_hit),
    .match_idx (rd_idx),
    .free_idx  (rd_free),
    .full      (rd_full)
  );

  bhc_match #(.PC_W(PC_W), .ENTRIES(ENTRIES)) u_upd_match (
    .entries   (entries),
    .addr      (update_pc),
    .hit       (upd_hit),
    .match_idx (upd_idx),
    .free_idx  (upd_free),
    .full      (upd_full)
  );

  logic [HIST_W-1:0] new_hist;
  logic [IDX_W-1:0]  tgt_idx;
  logic              victim;

  always_comb begin
    new_hist = {{(HIST_W-1){1'b0}}, branch_taken};
    tgt_idx  = upd_free;
    victim   = 1'b0;
    if (upd_hit) begin
      new_hist = shift_hist(entries[upd_idx].hist, branch_taken);
      tgt_idx  = upd_idx;
    end else if (upd_full) begin
      tgt_idx = rr;
      victim  = 1'b1;
    end
  end

  // Outputs are held at zero throughout reset, including any forwarded value.
  always_comb begin
    update_history = '0;
    evict          = 1'b0;
    read_hit       = 1'b0;
    read_history   = '0;
    if (rst) begin
      if (we) begin
        update_history = new_hist;
        evict          = victim;
      end
      read_hit     = rd_hit;
      read_history = rd_hit ? entries[rd_idx].hist : '0;
`ifdef BHC_BYPASS_EN
      if (we && (update_pc == pc)) begin
        read_hit     = 1'b1;
        read_history = new_hist;
      end
`endif
    end
  end

  // NOTE: the entry array is a small flop-based register file, so it is reset; valid bits must be known from the first lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
      rr <= '0;
    end else if (we) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, matching the combinational outputs above.
      entries[tgt_idx] <= '{valid: 1'b1, tag: update_pc, hist: new_hist};
      if (victim) rr <= rr + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_history_cache.sv
// Directed self-checking bench for branch_history_cache (either BHC_BYPASS_EN setting).
module tb_branch_history_cache;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic       branch_taken;
  logic [9:0] pc;
  logic [9:0] update_pc;
  logic [2:0] read_history;
  logic       read_hit;
  logic [2:0] update_history;
  logic       evict;

  int checks   = 0;
  int failures = 0;

`ifdef BHC_BYPASS_EN
  localparam logic       BYP_HIT  = 1'b1;
  localparam logic [2:0] BYP_HIST = 3'b001;
`else
  localparam logic       BYP_HIT  = 1'b0;
  localparam logic [2:0] BYP_HIST = 3'b000;
`endif

  always #5 clk = ~clk;

  branch_history_cache dut (
    .clk            (clk),
    .rst            (rst),
    .we             (we),
    .branch_taken   (branch_taken),
    .pc             (pc),
    .update_pc      (update_pc),
    .read_history   (read_history),
    .read_hit       (read_hit),
    .update_history (update_history),
    .evict          (evict)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the committing edge.
  task automatic write_step(input logic [9:0] addr, input logic taken,
                            input logic [2:0] exp_hist, input logic exp_evict, input string tag);
    we           = 1'b1;
    update_pc    = addr;
    branch_taken = taken;
    @(negedge clk);
    check({tag, ".update_history"}, 32'(update_history), 32'(exp_hist));
    check({tag, ".evict"},          32'(evict),          32'(exp_evict));
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic read_check(input logic [9:0] addr, input logic exp_hit,
                            input logic [2:0] exp_hist, input string tag);
    pc = addr;
    #1;
    check({tag, ".read_hit"},     32'(read_hit),     32'(exp_hit));
    check({tag, ".read_history"}, 32'(read_history), 32'(exp_hist));
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    we           = 1'b1;
    branch_taken = 1'b1;
    pc           = 10'h004;
    update_pc    = 10'h004;

    // Reset held two cycles with a write presented: everything reads zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.read_hit",       32'(read_hit),       32'd0);
    check("rst.read_history",   32'(read_history),   32'd0);
    check("rst.evict",          32'(evict),          32'd0);
    check("rst.update_history", 32'(update_history), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    we = 1'b0;
    rst = 1'b1;

    // First write into an empty cache, with the read port on the same PC.
    pc           = 10'h004;
    we           = 1'b1;
    update_pc    = 10'h004;
    branch_taken = 1'b1;
    @(negedge clk);
    check("first.update_history", 32'(update_history), 32'(3'b001));
    check("first.evict",          32'(evict),          32'd0);
    check("bypass.read_hit",      32'(read_hit),       32'(BYP_HIT));
    check("bypass.read_history",  32'(read_history),   32'(BYP_HIST));
    @(posedge clk);
    #1 we = 1'b0;
    read_check(10'h004, 1'b1, 3'b001, "first.read");

    // History shifting on repeated hits.
    write_step(10'h004, 1'b1, 3'b011, 1'b0, "second");
    read_check(10'h004, 1'b1, 3'b011, "second.read");
    write_step(10'h004, 1'b1, 3'b111, 1'b0, "third");
    write_step(10'h004, 1'b0, 3'b110, 1'b0, "fourth");
    read_check(10'h004, 1'b1, 3'b110, "fourth.read");
    read_check(10'h005, 1'b0, 3'b000, "other.miss");

    // Fill from empty, then round-robin eviction starting at entry 0.
    pulse_reset();
    read_check(10'h004, 1'b0, 3'b000, "cleared");
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      a = 10'h010 + 10'(i);
      write_step(a, a[0], {2'b00, a[0]}, 1'b0, $sformatf("fill%0d", i));
    end
    write_step(10'h020, 1'b1, 3'b001, 1'b1, "evict0");
    read_check(10'h010, 1'b0, 3'b000, "evict0.old");
    read_check(10'h020, 1'b1, 3'b001, "evict0.new");
    read_check(10'h011, 1'b1, 3'b001, "evict0.keep");
    write_step(10'h021, 1'b0, 3'b000, 1'b1, "evict1");
    read_check(10'h011, 1'b0, 3'b000, "evict1.old");
    read_check(10'h012, 1'b1, 3'b000, "evict1.keep");
    write_step(10'h013, 1'b1, 3'b011, 1'b0, "full.hit");
    read_check(10'h013, 1'b1, 3'b011, "full.hit.read");

    // Reset asserted in the middle of a write cycle.
    we           = 1'b1;
    update_pc    = 10'h022;
    branch_taken = 1'b1;
    pc           = 10'h020;
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst.update_history", 32'(update_history), 32'd0);
    check("midrst.evict",          32'(evict),          32'd0);
    check("midrst.read_hit",       32'(read_hit),       32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    we = 1'b0;
    read_check(10'h020, 1'b0, 3'b000, "midrst.old");
    read_check(10'h022, 1'b0, 3'b000, "midrst.dropped");
    read_check(10'h013, 1'b0, 3'b000, "midrst.cleared");

    // Round-robin pointer restarts at 0 after reset.
    for (int i = 0; i < 8; i++) begin
      write_step(10'h030 + 10'(i), 1'b1, 3'b001, 1'b0, $sformatf("refill%0d", i));
    end
    write_step(10'h040, 1'b0, 3'b000, 1'b1, "rr_restart");
    read_check(10'h030, 1'b0, 3'b000, "rr_restart.victim");
    read_check(10'h031, 1'b1, 3'b001, "rr_restart.keep");
    read_check(10'h040, 1'b1, 3'b000, "rr_restart.new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
